// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one solver RAM port among up to four requesters.
// Grants are combinational; accepted commands are registered onto the ram_* bus.
// Read returns are steered back to the issuing requester after the RAM latency.
module ram_port_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned AW     = 64,
    parameter int unsigned DW     = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        ram_address,
    output logic [DW-1:0]        ram_wdata,
    output logic                 ram_WR_RD,
    output logic                 ram_cmd,
    input  logic [DW-1:0]        ram_rdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One spare bit so pointer + offset never overflows before the wrap.
    localparam int unsigned PW = IW + 1;

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [IW-1:0]               r_owner;
    logic [IW-1:0]               w_owner_nxt;
    logic [IW-1:0]               r_rr_ptr;
    logic [IW-1:0]               w_rr_ptr_nxt;

    logic [NREQ-1:0]             w_gnt;
    logic [IW-1:0]               w_idx;
    logic                        w_acc;

    logic [AW-1:0]               r_ram_address;
    logic [DW-1:0]               r_ram_wdata;
    logic                        r_ram_wr;
    logic                        r_ram_cmd;

    logic [RD_LAT-1:0]           r_pipe_vld;
    logic [RD_LAT-1:0][IW-1:0]   r_pipe_idx;
    logic [NREQ-1:0]             r_rvalid;
    logic [DW-1:0]               r_rdata;

    // (v + 1) mod NREQ
    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
        logic [PW-1:0] t;
        t = {1'b0, v} + PW'(1);
        if (t >= PW'(NREQ)) begin
            t = '0;
        end
        return t[IW-1:0];
    endfunction

    // Grant selection: hold the owner while locked, else scan from rr_ptr with wrap.
    always_comb begin
        logic [PW-1:0] p;
        logic          found;
        w_gnt = '0;
        w_idx = '0;
        found = 1'b0;
        p     = '0;
        if (rst) begin
            if (r_state == StOwned) begin
                if (req[r_owner]) begin
                    found = 1'b1;
                    w_idx = r_owner;
                end
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    p = {1'b0, r_rr_ptr} + PW'(k);
                    if (p >= PW'(NREQ)) begin
                        p = p - PW'(NREQ);
                    end
                    if (!found && req[p[IW-1:0]]) begin
                        found = 1'b1;
                        w_idx = p[IW-1:0];
                    end
                end
            end
            w_gnt[w_idx] = found;
        end
    end

    assign gnt   = w_gnt;
    assign w_acc = |w_gnt;

    // Next-state: lock keeps ownership; release or owner drop advances the pointer.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_acc) begin
            if (lock[w_idx]) begin
                w_state_nxt = StOwned;
                w_owner_nxt = w_idx;
            end else begin
                w_state_nxt  = StIdle;
                w_rr_ptr_nxt = inc_wrap(w_idx);
            end
        end else if (r_state == StOwned) begin
            w_state_nxt  = StIdle;
            w_rr_ptr_nxt = inc_wrap(r_owner);
        end
    end

    // FSM state, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Register the accepted command onto the RAM port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_address <= '0;
            r_ram_wdata   <= '0;
            r_ram_wr      <= 1'b0;
            r_ram_cmd     <= 1'b0;
        end else if (w_acc) begin
            r_ram_address <= addr[32'(w_idx)*AW +: AW];
            r_ram_wdata   <= wdata[32'(w_idx)*DW +: DW];
            r_ram_wr      <= we[w_idx];
            r_ram_cmd     <= 1'b1;
        end else begin
            r_ram_wr      <= 1'b0;
            r_ram_cmd     <= 1'b0;
        end
    end

    // Track issued reads and steer returning RAM data to the issuing requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_vld <= '0;
            r_pipe_idx <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
        end else begin
            r_pipe_vld[0] <= w_acc & ~we[w_idx];
            r_pipe_idx[0] <= w_idx;
            for (int unsigned s = RD_LAT - 1; s > 0; s--) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_idx[s] <= r_pipe_idx[s-1];
            end
            r_rvalid <= '0;
            if (r_pipe_vld[RD_LAT-1]) begin
                r_rvalid[r_pipe_idx[RD_LAT-1]] <= 1'b1;
                r_rdata                        <= ram_rdata;
            end
        end
    end

    assign ram_address = r_ram_address;
    assign ram_wdata   = r_ram_wdata;
    assign ram_WR_RD   = r_ram_wr;
    assign ram_cmd     = r_ram_cmd;
    assign rvalid      = r_rvalid;
    assign rdata       = r_rdata;

endmodule
